div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider with HI/LO result registers.
// Handles signed/unsigned divide, divide-by-zero, flush, and mthi/mtlo writes.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted here
// RUN   | one radix-2 restoring step per cycle, 32 steps
// FIX   | sign correction and HI/LO write-back, done pulse
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic [31:0] origDividend;
    logic        negQuo;
    logic        negRem;
    logic        zeroDiv;
    logic [32:0] partial;
    logic [32:0] diff;

    // quo starts as |dividend| and is shifted out MSB-first into the partial remainder
    always_comb begin
        partial = {rem, quo[31]};
        diff    = partial - {1'b0, dvsr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= 5'd0;
            quo          <= 32'd0;
            rem          <= 32'd0;
            dvsr         <= 32'd0;
            origDividend <= 32'd0;
            negQuo       <= 1'b0;
            negRem       <= 1'b0;
            zeroDiv      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        quo          <= (is_signed && dividend[31]) ? -dividend : dividend;
                        dvsr         <= (is_signed && divisor[31]) ? -divisor : divisor;
                        rem          <= 32'd0;
                        negQuo       <= is_signed && (dividend[31] ^ divisor[31]);
                        negRem       <= is_signed && dividend[31];
                        origDividend <= dividend;
                        zeroDiv      <= (divisor == 32'd0);
                        count        <= 5'd0;
                        div_by_zero  <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= partial[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) state <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        lo          <= zeroDiv ? 32'hFFFF_FFFF : (negQuo ? -quo : quo);
                        hi          <= zeroDiv ? origDividend : (negRem ? -rem : rem);
                        div_by_zero <= zeroDiv;
                        done        <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against a behavioural divide model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] expHi;
    logic [31:0] expLo;

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        r.dbz = 1'b0;
        if (b == 32'd0) begin
            r.lo  = 32'hFFFF_FFFF;
            r.hi  = a;
            r.dbz = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r.lo = 32'h8000_0000;
                r.hi = 32'd0;
            end else begin
                r.lo = $signed(a) / $signed(b);
                r.hi = $signed(a) % $signed(b);
            end
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // interfere: second start sampled on edge 5 and lo_we on edge 6, both must be ignored
    task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit interfere);
        exp_t e;
        exp_t got;
        int   lat;
        int   busyCnt;
        e = model(sgn, a, b);
        sb.push_back(e);
        @(negedge clk);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (interfere && lat == 4) begin start = 1'b1; dividend = 32'd8; divisor = 32'd2; end
            if (interfere && lat == 5) begin start = 1'b0; lo_we = 1'b1; wdata = 32'h5555_AAAA; end
            if (interfere && lat == 6) lo_we = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (busy) busyCnt++;
        end
        check("latency", lat, 33);
        check("busy_cycles", busyCnt, 33);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        got = sb.pop_front();
        check("lo", lo, got.lo);
        check("hi", hi, got.hi);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, got.dbz});
        expHi = got.hi;
        expLo = got.lo;
        @(posedge clk); #1;
        check("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   lat;
        logic doneSeen;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        runDiv(1'b0, 32'd100, 32'd7, 1'b0);
        check("divu_100_7_lo", lo, 32'd14);
        check("divu_100_7_hi", hi, 32'd2);
        runDiv(1'b1, -32'sd7, 32'd2, 1'b0);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        runDiv(1'b1, 32'd7, -32'sd2, 1'b0);
        runDiv(1'b0, 32'h1234_5678, 32'd0, 1'b0);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        check("dbz_hi", hi, 32'h1234_5678);
        check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_flag_cleared", {31'd0, div_by_zero}, 32'd0);
        runDiv(1'b1, 32'h1234_5678, 32'd0, 1'b0);
        runDiv(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 6; i++)
            runDiv(1'(i % 2), $urandom, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom, 1'b0);

        // preload LO, then flush a divide in RUN
        @(negedge clk); lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo", lo, 32'hDEAD_BEEF);
        expLo = 32'hDEAD_BEEF;
        @(negedge clk); is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        doneSeen = 1'b0;
        for (lat = 0; lat < 9; lat++) begin
            @(posedge clk); #1;
            doneSeen = doneSeen | done;
        end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) begin
            @(posedge clk); #1;
            doneSeen = doneSeen | done;
        end
        check("flush_no_done", {31'd0, doneSeen}, 32'd0);
        check("flush_lo", lo, expLo);
        check("flush_hi", hi, expHi);

        // flush landing on the FIX cycle suppresses the write-back
        @(negedge clk); dividend = 32'd20; divisor = 32'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (lat = 0; lat < 32; lat++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("fixflush_done", {31'd0, done}, 32'd0);
        check("fixflush_busy", {31'd0, busy}, 32'd0);
        check("fixflush_lo", lo, expLo);
        check("fixflush_hi", hi, expHi);

        // start together with flush in IDLE is dropped
        @(negedge clk); start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {31'd0, busy}, 32'd0);

        runDiv(1'b0, 32'd9, 32'd3, 1'b1);
        check("ignored_lo", lo, 32'd3);
        check("ignored_hi", hi, 32'd0);

        // asynchronous reset in the middle of a divide
        @(negedge clk); hi_we = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk); hi_we = 1'b0;
        check("mthi", hi, 32'hCAFE_0001);
        @(negedge clk); dividend = 32'h0000_FFFF; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (lat = 0; lat < 20; lat++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        runDiv(1'b0, 32'd10, 32'd3, 1'b0);
        check("post_rst_lo", lo, 32'd3);
        check("post_rst_hi", hi, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
